// File: rtl/max_argmax_pkg.sv
// Shared helpers for the max/argmax compare-select tree (top: max_argmax_pipe).
// Optional min/range path is controlled by MAX_ARGMAX_MIN_EN at the top level.
package max_argmax_pkg;

   localparam logic SEL_MAX = 1'b0;
   localparam logic SEL_MIN = 1'b1;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? int'($clog2(n)) : 1;
   endfunction

   // Live elements entering level k of a pairwise tree over n leaves.
   function automatic int unsigned level_cnt(input int unsigned n, input int unsigned k);
      return (n + (32'd1 << k) - 32'd1) >> k;
   endfunction

endpackage

// File: rtl/max_argmax_node.sv
// Two-input registered compare-select; ties keep input a (the lower channel index).
module max_argmax_node
   import max_argmax_pkg::*;
#(
   parameter int unsigned W     = 10,
   parameter int unsigned IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [W-1:0]     a,
   input  logic [IDX_W-1:0] a_idx,
   input  logic [W-1:0]     b,
   input  logic [IDX_W-1:0] b_idx,
   input  logic             sel_min,
   output logic [W-1:0]     out,
   output logic [IDX_W-1:0] out_idx
);

   logic             take_b_c;
   logic [W-1:0]     out_d, out_q;
   logic [IDX_W-1:0] idx_d, idx_q;

   // Strict compare so equal values never select b.
   always_comb begin
      take_b_c = (sel_min == SEL_MIN) ? (b < a) : (b > a);
      out_d    = out_q;
      idx_d    = idx_q;
      if (en) begin
         out_d = take_b_c ? b : a;
         idx_d = take_b_c ? b_idx : a_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
         idx_q <= '0;
      end else begin
         out_q <= out_d;
         idx_q <= idx_d;
      end
   end

   assign out     = out_q;
   assign out_idx = idx_q;

endmodule

// File: rtl/max_argmax_pipe.sv
// Pipelined N-channel max/argmax with valid/ready streaming and global stall.
// Define MAX_ARGMAX_MIN_EN to add a parallel min tree plus out_min/out_min_idx/out_range.
module max_argmax_pipe
   import max_argmax_pkg::*;
#(
   parameter int unsigned W       = 10,
   parameter int unsigned N       = 3,
   localparam int unsigned IDX_W  = clog2_min1(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N*W-1:0]   in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_max,
   output logic [IDX_W-1:0] out_index
`ifdef MAX_ARGMAX_MIN_EN
   ,
   output logic [W-1:0]     out_min,
   output logic [IDX_W-1:0] out_min_idx,
   output logic [W-1:0]     out_range
`endif
);

   localparam int unsigned L = clog2_min1(N);
`ifdef MAX_ARGMAX_MIN_EN
   localparam int unsigned NT = 2;
`else
   localparam int unsigned NT = 1;
`endif

   logic         advance_c;
   logic [L-1:0] vld_d, vld_q;

   // Whole pipe moves together; it only freezes when the output is full and blocked.
   always_comb begin
      advance_c = !vld_q[L-1] || out_ready;
      vld_d     = vld_q;
      if (advance_c) begin
         vld_d = (vld_q << 1) | L'(in_valid);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   for (genvar k = 0; k < L; k++) begin : g_lvl
      localparam int unsigned CI = level_cnt(N, k);
      localparam int unsigned CO = level_cnt(N, k + 1);

      logic                          en_c;
      logic [NT-1:0][CI*W-1:0]       v_in;
      logic [NT-1:0][CI*IDX_W-1:0]   i_in;
      logic [NT-1:0][CO*W-1:0]       v_out;
      logic [NT-1:0][CO*IDX_W-1:0]   i_out;

      if (k == 0) begin : g_src
         assign en_c = advance_c & in_valid;
         for (genvar t = 0; t < NT; t++) begin : g_tree
            assign v_in[t] = in_data;
            for (genvar i = 0; i < CI; i++) begin : g_idx
               assign i_in[t][i*IDX_W +: IDX_W] = IDX_W'(i);
            end
         end
      end else begin : g_src
         assign en_c = advance_c & vld_q[k-1];
         assign v_in = g_lvl[k-1].v_out;
         assign i_in = g_lvl[k-1].i_out;
      end

      for (genvar t = 0; t < NT; t++) begin : g_tree
         for (genvar j = 0; j < CO; j++) begin : g_el
            if (2*j + 1 < CI) begin : g_pair
               max_argmax_node #(.W(W), .IDX_W(IDX_W)) u_node (
                  .clk     (clk),
                  .rst_n   (rst_n),
                  .en      (en_c),
                  .a       (v_in[t][2*j*W +: W]),
                  .a_idx   (i_in[t][2*j*IDX_W +: IDX_W]),
                  .b       (v_in[t][(2*j+1)*W +: W]),
                  .b_idx   (i_in[t][(2*j+1)*IDX_W +: IDX_W]),
                  .sel_min ((t == 1) ? SEL_MIN : SEL_MAX),
                  .out     (v_out[t][j*W +: W]),
                  .out_idx (i_out[t][j*IDX_W +: IDX_W])
               );
            end else begin : g_pass
               // Odd element out rides to the next level untouched.
               logic [W-1:0]     val_d, val_q;
               logic [IDX_W-1:0] idx_d, idx_q;

               always_comb begin
                  val_d = val_q;
                  idx_d = idx_q;
                  if (en_c) begin
                     val_d = v_in[t][2*j*W +: W];
                     idx_d = i_in[t][2*j*IDX_W +: IDX_W];
                  end
               end

               always_ff @(posedge clk or negedge rst_n) begin
                  if (!rst_n) begin
                     val_q <= '0;
                     idx_q <= '0;
                  end else begin
                     val_q <= val_d;
                     idx_q <= idx_d;
                  end
               end

               assign v_out[t][j*W +: W]         = val_q;
               assign i_out[t][j*IDX_W +: IDX_W] = idx_q;
            end
         end
      end
   end

   assign in_ready  = advance_c;
   assign out_valid = vld_q[L-1];
   assign out_max   = g_lvl[L-1].v_out[0];
   assign out_index = g_lvl[L-1].i_out[0];

`ifdef MAX_ARGMAX_MIN_EN
   localparam int unsigned CL = level_cnt(N, L - 1);

   logic [CL*W-1:0] last_max_in, last_min_in;
   logic [W-1:0]    hi_c, lo_c, rng_d, rng_q;

   assign last_max_in = g_lvl[L-1].v_in[0];
   assign last_min_in = g_lvl[L-1].v_in[1];

   // Range uses the last level's own selections so it lands with max/min.
   if (CL > 1) begin : g_rng2
      always_comb begin
         hi_c = (last_max_in[2*W-1:W] > last_max_in[W-1:0]) ? last_max_in[2*W-1:W]
                                                            : last_max_in[W-1:0];
         lo_c = (last_min_in[2*W-1:W] < last_min_in[W-1:0]) ? last_min_in[2*W-1:W]
                                                            : last_min_in[W-1:0];
      end
   end else begin : g_rng1
      assign hi_c = last_max_in[W-1:0];
      assign lo_c = last_min_in[W-1:0];
   end

   always_comb begin
      rng_d = rng_q;
      if (g_lvl[L-1].en_c) begin
         rng_d = hi_c - lo_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rng_q <= '0;
      end else begin
         rng_q <= rng_d;
      end
   end

   assign out_min     = g_lvl[L-1].v_out[1];
   assign out_min_idx = g_lvl[L-1].i_out[1];
   assign out_range   = rng_q;
`endif

endmodule

// File: tb/tb_max_argmax_pipe.sv
// Randomised and directed bench for max_argmax_pipe (N=3, W=10) against a linear-scan model.
`timescale 1ns/1ps
module tb_max_argmax_pipe;

   localparam int unsigned W     = 10;
   localparam int unsigned N     = 3;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned LAT   = 2;

   typedef struct packed {
      logic [W-1:0]     mx;
      logic [IDX_W-1:0] mx_i;
      logic [W-1:0]     mn;
      logic [IDX_W-1:0] mn_i;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [N*W-1:0]   in_data;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_max;
   logic [IDX_W-1:0] out_index;
`ifdef MAX_ARGMAX_MIN_EN
   logic [W-1:0]     out_min;
   logic [IDX_W-1:0] out_min_idx;
   logic [W-1:0]     out_range;
`endif

   int   errors = 0;
   int   checks = 0;
   int   n_out  = 0;
   exp_t exp_q[$];

   max_argmax_pipe #(.W(W), .N(N)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_index (out_index)
`ifdef MAX_ARGMAX_MIN_EN
      ,
      .out_min     (out_min),
      .out_min_idx (out_min_idx),
      .out_range   (out_range)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: left-to-right scan, replace only on strictly better -> lowest index wins ties.
   function automatic exp_t ref_model(input logic [N*W-1:0] d);
      exp_t         r;
      logic [W-1:0] v;
      r.mx   = d[W-1:0];
      r.mn   = d[W-1:0];
      r.mx_i = '0;
      r.mn_i = '0;
      for (int i = 1; i < N; i++) begin
         v = d[i*W +: W];
         if (v > r.mx) begin r.mx = v; r.mx_i = IDX_W'(i); end
         if (v < r.mn) begin r.mn = v; r.mn_i = IDX_W'(i); end
      end
      return r;
   endfunction

   function automatic logic [N*W-1:0] vec3(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
      return {W'(c), W'(b), W'(a)};
   endfunction

   function automatic logic [N*W-1:0] rand_vec();
      logic [N*W-1:0] d;
      for (int i = 0; i < N; i++) begin
         case ($urandom_range(0, 3))
            0:       d[i*W +: W] = '0;
            1:       d[i*W +: W] = '1;
            2:       d[i*W +: W] = W'($urandom_range(0, 3));
            default: d[i*W +: W] = W'($urandom);
         endcase
      end
      return d;
   endfunction

   // One clock: drive at negedge, score outputs before the next rising edge.
   task automatic step(input logic v, input logic [N*W-1:0] d, input logic rdy);
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      #1;
      if (exp_q.size() == 0) begin
         check("idle_out_valid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
         e = exp_q[0];
         check("out_max", 32'(out_max), 32'(e.mx));
         check("out_index", 32'(out_index), 32'(e.mx_i));
`ifdef MAX_ARGMAX_MIN_EN
         check("out_min", 32'(out_min), 32'(e.mn));
         check("out_min_idx", 32'(out_min_idx), 32'(e.mn_i));
         check("out_range", 32'(out_range), 32'(e.mx - e.mn));
`endif
         if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
         end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(d));
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         step(1'b0, '0, 1'b1);
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic directed(input string tag, input int unsigned a, input int unsigned b,
                           input int unsigned c, input int unsigned emx, input int unsigned emxi,
                           input int unsigned emn, input int unsigned emni);
      step(1'b1, vec3(a, b, c), 1'b1);
      for (int i = 1; i < int'(LAT); i++) begin
         step(1'b0, '0, 1'b1);
         check({tag, "_early"}, 32'(out_valid), 32'd0);
      end
      step(1'b0, '0, 1'b1);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_max"}, 32'(out_max), emx);
      check({tag, "_idx"}, 32'(out_index), emxi);
`ifdef MAX_ARGMAX_MIN_EN
      check({tag, "_min"}, 32'(out_min), emn);
      check({tag, "_min_idx"}, 32'(out_min_idx), emni);
      check({tag, "_range"}, 32'(out_range), emx - emn);
`else
      if (emn > emx || emni >= N) check({tag, "_min_args"}, 32'(emn), 32'(emx));
`endif
      step(1'b0, '0, 1'b1);
      check({tag, "_one_cycle"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N*W-1:0] bp [4];
      int             p;
      int             n0;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_max", 32'(out_max), 32'd0);
      check("rst_out_index", 32'(out_index), 32'd0);
`ifdef MAX_ARGMAX_MIN_EN
      check("rst_out_range", 32'(out_range), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", 32'(in_ready), 32'd1);

      directed("basic", 5, 9, 3, 9, 1, 3, 2);
      directed("tie_772", 7, 7, 2, 7, 0, 2, 2);
      directed("tie_444", 4, 4, 4, 4, 0, 4, 0);
      directed("tie_188", 1, 8, 8, 8, 1, 1, 0);
      directed("tie_edge", 1023, 0, 1023, 1023, 0, 0, 1);

      // Back-to-back stream with a 3-cycle stall as soon as the first result appears.
      bp[0] = vec3(1, 2, 3);
      bp[1] = vec3(6, 5, 4);
      bp[2] = vec3(0, 0, 9);
      bp[3] = vec3(8, 8, 8);
      p  = 0;
      n0 = n_out;
      for (int c = 0; c < 14; c++) begin
         step(1'(p < 4), (p < 4) ? bp[p] : '0, 1'(!(c >= 2 && c < 5)));
         if (c >= 2 && c < 5) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_max", 32'(out_max), 32'd3);
            check("bp_hold_idx", 32'(out_index), 32'd2);
         end
         if (in_valid && in_ready) p++;
      end
      check("bp_all_sent", 32'(p), 32'd4);
      check("bp_out_count", 32'(n_out - n0), 32'd4);
      drain(20);

      // Asynchronous reset with two vectors in flight.
      step(1'b1, vec3(100, 200, 300), 1'b1);
      step(1'b1, vec3(400, 500, 600), 1'b1);
      @(posedge clk);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_max", 32'(out_max), 32'd0);
      check("arst_out_index", 32'(out_index), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("arst_ready", 32'(in_ready), 32'd1);
      repeat (4) step(1'b0, '0, 1'b1);
      directed("post_rst", 5, 9, 3, 9, 1, 3, 2);

      // Full throughput: one vector per clock, fixed latency.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, rand_vec(), 1'b1);
         check("burst_in_ready", 32'(in_ready), 32'd1);
      end
      repeat (LAT - 1) step(1'b0, '0, 1'b1);
      check("burst_last_pending", 32'(exp_q.size()), 32'd1);
      step(1'b0, '0, 1'b1);
      check("burst_done", 32'(exp_q.size()), 32'd0);

      // Random traffic with random backpressure.
      n0 = n_out;
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 9) < 7), rand_vec(), 1'($urandom_range(0, 9) < 6));
      end
      drain(20);
      check("rand_progress", 32'(n_out - n0 > 1000), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
